encoder_ctrl: RTL and testbench
===============================

ENCODER_CTRL -- requirements
Module: encoder_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2: consecutive equal synchronized samples needed before a filtered input changes.
REQ-002 Parameter POS_WIDTH, default 8: width of the position counter.
REQ-003 Parameter POS_MAX, default 99: upper position limit; lower limit is fixed at 0.
REQ-004 Parameter WRAP, default 1: 1 = wrap at the limits, 0 = saturate at the limits.
REQ-005 MAX10_CLK1_50  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enc_a  in  1  raw encoder channel A, asynchronous.
REQ-008 enc_b  in  1  raw encoder channel B, asynchronous.
REQ-009 zero  in  1  synchronous pulse: clear the position.
REQ-010 err_clr  in  1  synchronous pulse: clear the sticky error.
REQ-011 position  out  POS_WIDTH  current detent count.
REQ-012 step_inc  out  1  one-cycle pulse per completed clockwise detent.
REQ-013 step_dec  out  1  one-cycle pulse per completed counter-clockwise detent.
REQ-014 dir  out  1  direction of the last completed detent: 1 = clockwise.
REQ-015 err  out  1  sticky flag for an illegal quadrature transition.
REQ-016 wrapped  out  1  one-cycle pulse when position wraps or hits saturation.

Function
REQ-017 enc_a and enc_b SHALL each pass through a 2-FF synchronizer.
REQ-018 Each synchronized channel SHALL update its filtered value only after DEBOUNCE_CYCLES consecutive equal samples that differ from the current filtered value.
  - Any differing sample restarts the count.
REQ-019 Decoder FSM states: IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, ERR. Code AB is filtered {a,b}.
REQ-020 Clockwise path: IDLE(00) -> CW1(10) -> CW2(11) -> CW3(01) -> IDLE(00).
  - Completing the path SHALL assert step_inc and set dir=1.
REQ-021 Counter-clockwise path: IDLE(00) -> CCW1(01) -> CCW2(11) -> CCW3(10) -> IDLE(00).
  - Completing the path SHALL assert step_dec and set dir=0.
REQ-022 A code equal to the previous state's code SHALL move the FSM back one state (backtrack) without a step.
  - A backtrack from CW1 or CCW1 to 00 SHALL return to IDLE with no step.
REQ-023 An unchanged code SHALL hold the state.
REQ-024 A code change in which both bits differ SHALL enter ERR and set err.
  - ERR SHALL stay until the code is 00, then go to IDLE with no step.
REQ-025 step_inc, step_dec and the position update SHALL be registered on the same edge as the FSM return to IDLE.
  - Latency from a raw edge reaching 00: 2 (sync) + DEBOUNCE_CYCLES + 1 clocks.
REQ-026 On step_inc at POS_MAX: WRAP=1 gives 0; WRAP=0 holds POS_MAX. Either case SHALL pulse wrapped.
REQ-027 On step_dec at 0: WRAP=1 gives POS_MAX; WRAP=0 holds 0. Either case SHALL pulse wrapped.
REQ-028 zero SHALL force position to 0 next cycle and take priority over a simultaneous step.
  - The step pulse is still emitted; wrapped is suppressed.
REQ-029 err_clr SHALL clear err unless an illegal transition occurs in the same cycle, in which case err stays 1.
REQ-030 Arithmetic SHALL be unsigned, POS_WIDTH bits; POS_MAX SHALL be less than 2^POS_WIDTH.

Reset
REQ-031 Reset values: position=0, step_inc=0, step_dec=0, dir=1, err=0, wrapped=0, FSM=IDLE.
  - Synchronizers and filtered values = 0; debounce counters = 0.
REQ-032 Reset asserted mid-sequence SHALL discard the partial detent; no step is emitted after release until a full new path completes.

Structure
REQ-033 A shared package encoder_pkg SHALL hold the FSM state enumeration and the AB code constants (00, 10, 11, 01).
REQ-034 Synchronizer plus debounce SHALL be one sub-module, encoder_debounce, instantiated once per channel.

Verification
REQ-035 Clockwise: A high then B high, A low, B low, each held 5 clocks, from position 0 -> one step_inc, position=1, dir=1.
REQ-036 Counter-clockwise: full path from position 0, WRAP=1 -> step_dec, position=99, wrapped pulse.
  - Same stimulus with WRAP=0 -> position stays 0, wrapped pulse.
REQ-037 Glitch: A high for 1 clock with DEBOUNCE_CYCLES=2 -> no filtered change, no state change, position unchanged.
REQ-038 Illegal jump: AB 00 -> 11 -> err=1, FSM=ERR.
  - Then 00 -> IDLE, no step.
  - err_clr -> err=0.
REQ-039 Backtrack: 00 -> 10 -> 11 -> 10 -> 00 -> no step, position unchanged, err=0.
REQ-040 Priority/reset: zero coincident with step_inc at position 5 -> position=0.
  - Reset asserted in CW2 -> all outputs at reset values immediately; after release, 01 -> 00 -> no step.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants for the quadrature encoder controller: decoder state
// codes and the filtered {A,B} channel codes that the decoder walks through.
package encoder_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CW1  = 3'd1;
  localparam logic [2:0] ST_CW2  = 3'd2;
  localparam logic [2:0] ST_CW3  = 3'd3;
  localparam logic [2:0] ST_CCW1 = 3'd4;
  localparam logic [2:0] ST_CCW2 = 3'd5;
  localparam logic [2:0] ST_CCW3 = 3'd6;
  localparam logic [2:0] ST_ERR  = 3'd7;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;

endpackage

// File: rtl/encoder_debounce.sv
// One encoder channel: 2-FF synchronizer followed by a counting debounce
// filter that accepts a new level only after DEBOUNCE_CYCLES steady samples.
module encoder_debounce #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic [CNT_W-1:0] cnt;

  // A sample equal to the filtered level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      cnt      <= '0;
      filtered <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != filtered) begin
        if (cnt == CNT_LAST) begin
          filtered <= sync2;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/encoder_ctrl.sv
// Quadrature encoder controller: debounced channels feed a detent decoder
// that drives a wrapping or saturating position counter.
module encoder_ctrl
  import encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int POS_WIDTH       = 8,
  parameter int POS_MAX         = 99,
  parameter int WRAP            = 1
) (
  input  logic                 MAX10_CLK1_50,
  input  logic                 reset,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 zero,
  input  logic                 err_clr,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_inc,
  output logic                 step_dec,
  output logic                 dir,
  output logic                 err,
  output logic                 wrapped
);

  localparam logic [POS_WIDTH-1:0] POS_LIMIT = POS_WIDTH'(POS_MAX);

  logic a_filt;
  logic b_filt;
  logic [1:0] code;
  logic [2:0] state;
  logic [2:0] state_next;
  logic inc_now;
  logic dec_now;
  logic illegal;
  logic wrap_now;
  logic [POS_WIDTH-1:0] pos_next;

  encoder_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk      (MAX10_CLK1_50),
    .reset    (reset),
    .raw      (enc_a),
    .filtered (a_filt)
  );

  encoder_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk      (MAX10_CLK1_50),
    .reset    (reset),
    .raw      (enc_b),
    .filtered (b_filt)
  );

  assign code = {a_filt, b_filt};

  // Each state accepts the next code, the previous code (backtrack) or its own
  // code; the remaining code differs in both bits and is illegal.
  always_comb begin
    state_next = state;
    inc_now    = 1'b0;
    dec_now    = 1'b0;
    illegal    = 1'b0;
    case (state)
      ST_IDLE: case (code)
        AB_10:   state_next = ST_CW1;
        AB_01:   state_next = ST_CCW1;
        AB_11:   begin state_next = ST_ERR; illegal = 1'b1; end
        default: ;
      endcase
      ST_CW1: case (code)
        AB_11:   state_next = ST_CW2;
        AB_00:   state_next = ST_IDLE;
        AB_01:   begin state_next = ST_ERR; illegal = 1'b1; end
        default: ;
      endcase
      ST_CW2: case (code)
        AB_01:   state_next = ST_CW3;
        AB_10:   state_next = ST_CW1;
        AB_00:   begin state_next = ST_ERR; illegal = 1'b1; end
        default: ;
      endcase
      ST_CW3: case (code)
        AB_00:   begin state_next = ST_IDLE; inc_now = 1'b1; end
        AB_11:   state_next = ST_CW2;
        AB_10:   begin state_next = ST_ERR; illegal = 1'b1; end
        default: ;
      endcase
      ST_CCW1: case (code)
        AB_11:   state_next = ST_CCW2;
        AB_00:   state_next = ST_IDLE;
        AB_10:   begin state_next = ST_ERR; illegal = 1'b1; end
        default: ;
      endcase
      ST_CCW2: case (code)
        AB_10:   state_next = ST_CCW3;
        AB_01:   state_next = ST_CCW1;
        AB_00:   begin state_next = ST_ERR; illegal = 1'b1; end
        default: ;
      endcase
      ST_CCW3: case (code)
        AB_00:   begin state_next = ST_IDLE; dec_now = 1'b1; end
        AB_11:   state_next = ST_CCW2;
        AB_01:   begin state_next = ST_ERR; illegal = 1'b1; end
        default: ;
      endcase
      ST_ERR: if (code == AB_00) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // zero overrides any step and hides the limit pulse.
  always_comb begin
    pos_next = position;
    wrap_now = 1'b0;
    if (zero) begin
      pos_next = '0;
    end else if (inc_now) begin
      if (position == POS_LIMIT) begin
        wrap_now = 1'b1;
        pos_next = (WRAP != 0) ? {POS_WIDTH{1'b0}} : POS_LIMIT;
      end else begin
        pos_next = position + 1'b1;
      end
    end else if (dec_now) begin
      if (position == {POS_WIDTH{1'b0}}) begin
        wrap_now = 1'b1;
        pos_next = (WRAP != 0) ? POS_LIMIT : {POS_WIDTH{1'b0}};
      end else begin
        pos_next = position - 1'b1;
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      position <= '0;
      step_inc <= 1'b0;
      step_dec <= 1'b0;
      dir      <= 1'b1;
      err      <= 1'b0;
      wrapped  <= 1'b0;
    end else begin
      state    <= state_next;
      position <= pos_next;
      step_inc <= inc_now;
      step_dec <= dec_now;
      wrapped  <= wrap_now;
      err      <= illegal | (err & ~err_clr);
      if (inc_now) dir <= 1'b1;
      else if (dec_now) dir <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encoder_ctrl.sv
// Bench for encoder_ctrl: directed detent scenarios plus random quadrature
// traffic, checked every cycle against a path-progress reference model.
module tb_encoder_ctrl;

  localparam int DEB = 2;
  localparam int PMAX = 99;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;
  logic zero = 1'b0;
  logic err_clr = 1'b0;

  logic [7:0] pos_w, pos_s;
  logic inc_w, dec_w, dir_w, err_w, wr_w;
  logic inc_s, dec_s, dir_s, err_s, wr_s;

  int compared = 0;
  int mismatched = 0;
  int inc_cnt = 0, dec_cnt = 0, wrw_cnt = 0, wrs_cnt = 0;

  // reference model state
  int m_pos_w = 0, m_pos_s = 0, m_prog = 0;
  bit m_in_err = 0, m_inc = 0, m_dec = 0, m_dir = 1, m_err = 0, m_wr_w = 0, m_wr_s = 0;
  bit m_fa = 0, m_fb = 0;
  bit hist_a[8];
  bit hist_b[8];

  always #5 clk = ~clk;

  encoder_ctrl #(.DEBOUNCE_CYCLES(DEB), .POS_WIDTH(8), .POS_MAX(PMAX), .WRAP(1)) dut_w (
    .MAX10_CLK1_50(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .zero(zero), .err_clr(err_clr), .position(pos_w), .step_inc(inc_w),
    .step_dec(dec_w), .dir(dir_w), .err(err_w), .wrapped(wr_w)
  );

  encoder_ctrl #(.DEBOUNCE_CYCLES(DEB), .POS_WIDTH(8), .POS_MAX(PMAX), .WRAP(0)) dut_s (
    .MAX10_CLK1_50(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .zero(zero), .err_clr(err_clr), .position(pos_s), .step_inc(inc_s),
    .step_dec(dec_s), .dir(dir_s), .err(err_s), .wrapped(wr_s)
  );

  function automatic logic [1:0] cw_code(input int i);
    case (i)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] ccw_code(input int i);
    case (i)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int next_pos(input int pos, input bit inc, input bit dec,
                                  input bit clr, input bit wrap, output bit wr);
    wr = 0;
    if (clr) return 0;
    if (inc) begin
      if (pos == PMAX) begin wr = 1; return wrap ? 0 : PMAX; end
      return pos + 1;
    end
    if (dec) begin
      if (pos == 0) begin wr = 1; return wrap ? PMAX : 0; end
      return pos - 1;
    end
    return pos;
  endfunction

  task automatic model_step();
    logic [1:0] code;
    bit inc, dec, ill, wr;
    bit diff_a, diff_b;
    if (reset) begin
      m_pos_w = 0; m_pos_s = 0; m_prog = 0; m_in_err = 0;
      m_inc = 0; m_dec = 0; m_dir = 1; m_err = 0; m_wr_w = 0; m_wr_s = 0;
      m_fa = 0; m_fb = 0;
      for (int i = 0; i < 8; i++) begin hist_a[i] = 0; hist_b[i] = 0; end
      return;
    end
    code = {m_fa, m_fb};
    inc = 0; dec = 0; ill = 0;
    // m_prog: +k = k codes into the clockwise path, -k = into counter-clockwise
    if (m_in_err) begin
      if (code == 2'b00) begin m_in_err = 0; m_prog = 0; end
    end else if (m_prog == 0) begin
      if (code == cw_code(1)) m_prog = 1;
      else if (code == ccw_code(1)) m_prog = -1;
      else if (code == 2'b11) ill = 1;
    end else if (m_prog > 0) begin
      if (code == cw_code((m_prog + 1) % 4)) begin
        if (m_prog == 3) begin m_prog = 0; inc = 1; end
        else m_prog = m_prog + 1;
      end else if (code == cw_code(m_prog - 1)) m_prog = m_prog - 1;
      else if (code != cw_code(m_prog)) ill = 1;
    end else begin
      if (code == ccw_code((1 - m_prog) % 4)) begin
        if (m_prog == -3) begin m_prog = 0; dec = 1; end
        else m_prog = m_prog - 1;
      end else if (code == ccw_code(-m_prog - 1)) m_prog = m_prog + 1;
      else if (code != ccw_code(-m_prog)) ill = 1;
    end
    if (ill) m_in_err = 1;
    m_inc = inc;
    m_dec = dec;
    if (inc) m_dir = 1;
    else if (dec) m_dir = 0;
    m_err = ill ? 1'b1 : (err_clr ? 1'b0 : m_err);
    m_pos_w = next_pos(m_pos_w, inc, dec, zero, 1'b1, wr); m_wr_w = wr;
    m_pos_s = next_pos(m_pos_s, inc, dec, zero, 1'b0, wr); m_wr_s = wr;
    // filtered level flips once the last DEB synchronized samples all disagree
    diff_a = 1; diff_b = 1;
    for (int j = 0; j < DEB; j++) begin
      if (hist_a[1 + j] == m_fa) diff_a = 0;
      if (hist_b[1 + j] == m_fb) diff_b = 0;
    end
    if (diff_a) m_fa = ~m_fa;
    if (diff_b) m_fb = ~m_fb;
    for (int i = 7; i > 0; i--) begin hist_a[i] = hist_a[i - 1]; hist_b[i] = hist_b[i - 1]; end
    hist_a[0] = enc_a;
    hist_b[0] = enc_b;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      check_output("position_wrap", 32'(pos_w), 32'(m_pos_w));
      check_output("position_sat", 32'(pos_s), 32'(m_pos_s));
      check_output("step_inc", 32'(inc_w), 32'(m_inc));
      check_output("step_dec", 32'(dec_w), 32'(m_dec));
      check_output("dir", 32'(dir_w), 32'(m_dir));
      check_output("err", 32'(err_w), 32'(m_err));
      check_output("wrapped_wrap", 32'(wr_w), 32'(m_wr_w));
      check_output("wrapped_sat", 32'(wr_s), 32'(m_wr_s));
      check_output("step_inc_sat", 32'(inc_s), 32'(m_inc));
      check_output("step_dec_sat", 32'(dec_s), 32'(m_dec));
      if (inc_w) inc_cnt++;
      if (dec_w) dec_cnt++;
      if (wr_w) wrw_cnt++;
      if (wr_s) wrs_cnt++;
    end
  end

  task automatic apply_stimulus(input logic [1:0] ab, input int cycles);
    enc_a = ab[1];
    enc_b = ab[0];
    repeat (cycles) @(negedge clk);
  endtask

  task automatic cw_detent();
    apply_stimulus(2'b10, 5);
    apply_stimulus(2'b11, 5);
    apply_stimulus(2'b01, 5);
    apply_stimulus(2'b00, 8);
  endtask

  task automatic ccw_detent();
    apply_stimulus(2'b01, 5);
    apply_stimulus(2'b11, 5);
    apply_stimulus(2'b10, 5);
    apply_stimulus(2'b00, 8);
  endtask

  initial begin
    int snap_inc, snap_dec, snap_ww, snap_ws;
    logic [1:0] cur;
    int hold, idx, r;
    bit bias;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("reset_position", 32'(pos_w), 32'd0);
    check_output("reset_dir", 32'(dir_w), 32'd1);
    check_output("reset_err", 32'(err_w), 32'd0);
    check_output("reset_step_inc", 32'(inc_w), 32'd0);

    cw_detent();
    check_output("cw_count", 32'(inc_cnt), 32'd1);
    check_output("cw_position", 32'(pos_w), 32'd1);
    check_output("cw_dir", 32'(dir_w), 32'd1);

    ccw_detent();
    ccw_detent();
    check_output("ccw_wrap_position", 32'(pos_w), 32'd99);
    check_output("ccw_sat_position", 32'(pos_s), 32'd0);
    check_output("ccw_count", 32'(dec_cnt), 32'd2);
    check_output("ccw_wrapped_wrap", 32'(wrw_cnt), 32'd1);
    check_output("ccw_wrapped_sat", 32'(wrs_cnt), 32'd1);
    check_output("ccw_dir", 32'(dir_w), 32'd0);

    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
    @(negedge clk);
    repeat (5) cw_detent();
    check_output("five_steps_wrap", 32'(pos_w), 32'd5);
    check_output("five_steps_sat", 32'(pos_s), 32'd5);

    snap_inc = inc_cnt;
    snap_ww = wrw_cnt;
    apply_stimulus(2'b10, 5);
    apply_stimulus(2'b11, 5);
    apply_stimulus(2'b01, 5);
    enc_a = 1'b0;
    enc_b = 1'b0;
    repeat (4) @(negedge clk);
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
    repeat (4) @(negedge clk);
    check_output("zero_prio_position", 32'(pos_w), 32'd0);
    check_output("zero_prio_step", 32'(inc_cnt - snap_inc), 32'd1);
    check_output("zero_prio_wrapped", 32'(wrw_cnt - snap_ww), 32'd0);

    snap_inc = inc_cnt;
    snap_dec = dec_cnt;
    enc_a = 1'b1;
    @(negedge clk);
    apply_stimulus(2'b00, 8);
    check_output("glitch_position", 32'(pos_w), 32'd0);
    check_output("glitch_steps", 32'(inc_cnt + dec_cnt - snap_inc - snap_dec), 32'd0);
    check_output("glitch_err", 32'(err_w), 32'd0);

    apply_stimulus(2'b11, 6);
    check_output("illegal_err", 32'(err_w), 32'd1);
    check_output("illegal_err_sat", 32'(err_s), 32'd1);
    apply_stimulus(2'b00, 6);
    check_output("illegal_err_held", 32'(err_w), 32'd1);
    check_output("illegal_no_step", 32'(inc_cnt + dec_cnt - snap_inc - snap_dec), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check_output("err_clr", 32'(err_w), 32'd0);

    apply_stimulus(2'b10, 6);
    apply_stimulus(2'b11, 6);
    apply_stimulus(2'b10, 6);
    apply_stimulus(2'b00, 8);
    check_output("backtrack_steps", 32'(inc_cnt + dec_cnt - snap_inc - snap_dec), 32'd0);
    check_output("backtrack_position", 32'(pos_w), 32'd0);
    check_output("backtrack_err", 32'(err_w), 32'd0);

    repeat (3) cw_detent();
    check_output("pre_reset_position", 32'(pos_w), 32'd3);
    snap_inc = inc_cnt;
    snap_dec = dec_cnt;
    apply_stimulus(2'b10, 6);
    apply_stimulus(2'b11, 6);
    reset = 1'b1;
    #1;
    check_output("async_reset_position", 32'(pos_w), 32'd0);
    check_output("async_reset_step_inc", 32'(inc_w), 32'd0);
    check_output("async_reset_step_dec", 32'(dec_w), 32'd0);
    check_output("async_reset_dir", 32'(dir_w), 32'd1);
    check_output("async_reset_err", 32'(err_w), 32'd0);
    check_output("async_reset_wrapped", 32'(wr_w), 32'd0);
    enc_a = 1'b0;
    enc_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(2'b01, 6);
    apply_stimulus(2'b00, 8);
    check_output("post_reset_steps", 32'(inc_cnt + dec_cnt - snap_inc - snap_dec), 32'd0);
    check_output("post_reset_position", 32'(pos_w), 32'd0);

    cur = 2'b00;
    hold = 0;
    bias = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 800 == 0) bias = ~bias;
      if (hold <= 0) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (cw_code(k) == cur) idx = k;
        r = int'($urandom_range(0, 99));
        if (r < 70) idx = idx + (bias ? 1 : 3);
        else if (r < 85) idx = idx + (bias ? 3 : 1);
        else if (r < 95) idx = idx + 2;
        cur = cw_code(idx % 4);
        hold = int'($urandom_range(1, 8));
      end
      enc_a = cur[1];
      enc_b = cur[0];
      zero = ($urandom_range(0, 59) == 0);
      err_clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
      end
      @(negedge clk);
      hold--;
    end
    zero = 1'b0;
    err_clr = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
